// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional feature macro: REGFILE_MP_BYPASS_EN (same-edge write/scoreboard bypass on reads).
package regfile_pkg;

    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefAddrW   = 5;
    localparam int unsigned DefRdPorts = 2;
    localparam int unsigned DefWrPorts = 2;
    localparam int unsigned DefMaxPend = 4;

    // Width of a counter able to hold 0..size inclusive.
    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/regfile_pend.sv
// Pending-write scoreboard: one bit per register, set on reservation, cleared on writeback.
// Also keeps the popcount of pending bits and the reservation-ready flag.
module regfile_pend
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned SIZE     = 2 ** ADDR_W,
    parameter int unsigned MAX_PEND = DefMaxPend
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         stall,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    input  logic [SIZE-1:0]              clr,
    output logic [SIZE-1:0]              pend,
    output logic [SIZE-1:0]              pend_nxt,
    output logic                         rsv_rdy,
    output logic [cnt_width(SIZE)-1:0]   pend_cnt
);

    localparam int unsigned CntW = cnt_width(SIZE);

    logic [SIZE-1:0] pend_q, pend_d, set_vec;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsv_ok;

    // Depends only on the registered count, so there is no path from rsv_en.
    assign rsv_rdy  = (cnt_q < CntW'(MAX_PEND));
    assign pend     = pend_q;
    assign pend_nxt = pend_d;
    assign pend_cnt = cnt_q;

    // Resolve set/clear; a set on the same register as a clear wins (new op issued).
    always_comb begin
        rsv_ok  = en && !stall && rsv_en && (rsv_addr != '0) && rsv_rdy;
        set_vec = '0;
        if (rsv_ok) begin
            set_vec[rsv_addr] = 1'b1;
        end
        pend_d    = (pend_q & ~clr) | set_vec;
        pend_d[0] = 1'b0;
        cnt_d     = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            cnt_d = cnt_d + CntW'(pend_d[i]);
        end
    end

    // Scoreboard state; frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else if (en) begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, r0 hard-wired to zero and a
// pending-write scoreboard. Define REGFILE_MP_BYPASS_EN to forward same-edge
// writes and scoreboard updates into the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned SIZE     = 2 ** ADDR_W,
    parameter int unsigned RD_PORTS = DefRdPorts,
    parameter int unsigned WR_PORTS = DefWrPorts,
    parameter int unsigned MAX_PEND = DefMaxPend
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          stall,
    input  logic [RD_PORTS*ADDR_W-1:0]    rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]    rd_data,
    output logic [RD_PORTS-1:0]           rd_busy,
    input  logic [WR_PORTS-1:0]           wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]    wr_addr,
    input  logic [WR_PORTS*DATA_W-1:0]    wr_data,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic                          rsv_rdy,
    output logic [cnt_width(SIZE)-1:0]    pend_cnt
);

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic [DATA_W-1:0]          mem_q [SIZE];
    logic [DATA_W-1:0]          mem_d [SIZE];
    logic [SIZE-1:0]            wr_hit;
    logic [SIZE-1:0]            pend, pend_nxt;
    logic [RD_PORTS*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [RD_PORTS-1:0]        rd_busy_q, rd_busy_d;

    regfile_pend #(
        .ADDR_W   (ADDR_W),
        .SIZE     (SIZE),
        .MAX_PEND (MAX_PEND)
    ) u_pend (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .stall    (stall),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr      (wr_hit),
        .pend     (pend),
        .pend_nxt (pend_nxt),
        .rsv_rdy  (rsv_rdy),
        .pend_cnt (pend_cnt)
    );

    // Write-port resolution: later (higher-index) ports overwrite earlier ones.
    always_comb begin
        mem_d  = mem_q;
        wr_hit = '0;
        for (int p = 0; p < int'(WR_PORTS); p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0)) begin
                mem_d[wr_addr[p*ADDR_W +: ADDR_W]]  = wr_data[p*DATA_W +: DATA_W];
                wr_hit[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // Register array; r0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (en) begin
            mem_q <= mem_d;
        end
    end

    // Read muxing: bypass selects post-update state, otherwise pre-edge state.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int i = 0; i < int'(RD_PORTS); i++) begin
            if (rd_addr[i*ADDR_W +: ADDR_W] != '0) begin
                rd_data_d[i*DATA_W +: DATA_W] = Bypass ? mem_d[rd_addr[i*ADDR_W +: ADDR_W]]
                                                       : mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
                rd_busy_d[i] = Bypass ? pend_nxt[rd_addr[i*ADDR_W +: ADDR_W]]
                                      : pend[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Read registers hold during stall or disable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else if (en && !stall) begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-port, parametrised register file with a pending-write scoreboard for the core's issue/writeback path. It provides RD_PORTS registered read ports with zero-register semantics and WR_PORTS writeback ports. A per-register pending bit is set at issue of a long-latency op and cleared on writeback, with a bounded outstanding-reservation counter. Instantiated once per core, between decode/issue and writeback.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- SIZE, 2**ADDR_W, number of architectural registers, r0 included
- RD_PORTS, 2, number of read ports
- WR_PORTS, 2, number of writeback ports
- MAX_PEND, 4, maximum simultaneously pending registers, 1..SIZE-1
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global enable; 0 freezes all state
- stall  in  1  pipeline stall; freezes reads and reservations only
- rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*DATA_W  registered read data
- rd_busy  out  RD_PORTS  registered pending flag of the addressed register
- wr_en  in  WR_PORTS  per-port write strobe
- wr_addr  in  WR_PORTS*ADDR_W  packed write addresses
- wr_data  in  WR_PORTS*DATA_W  packed write data
- rsv_en  in  1  reserve request: mark rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- rsv_rdy  out  1  combinational; 1 when pend_cnt < MAX_PEND
- pend_cnt  out  $clog2(SIZE)+1  number of pending bits set

## Operation
- Reset (rst_n=0 at edge): every register clears to 0, all pending bits clear, rd_data=0, rd_busy=0, pend_cnt=0. rst_n overrides en.
- r0: reads return 0 with busy 0; writes and reservations to r0 are ignored.
- Writes, when en=1 (independent of stall): each port with wr_en=1 and wr_addr!=0 writes its data. If several ports target the same address, the highest-index port wins. A write clears that register's pending bit.
- Reservation, when en=1, stall=0, rsv_en=1, rsv_addr!=0 and rsv_rdy=1: sets the pending bit.
  - Reserving an already-pending register leaves the count unchanged.
  - A request with rsv_rdy=0 is dropped, and the requester must hold it.
- Same cycle, same address, write and reservation: the reservation wins, and the pending bit stays or becomes set (new op issued after the old writeback).
- pend_cnt always equals the popcount of the pending bits. Per edge it changes by (new sets) − (clears).
- Reads, when en=1 and stall=0: each port latches data and busy for its address. They hold otherwise.

## Timing
- Read latency 1 cycle: address at edge N, data/busy valid after edge N.
- Write visible to a plain read on the following edge.
- rsv_rdy is combinational from pend_cnt, with no path from rsv_en.
- Reservation affects rd_busy from the next read edge onward.
- Stall cycles still retire writebacks. Pending bits can therefore clear while the read outputs are frozen, and rd_busy is refreshed on the first non-stall edge.

## Configuration
- REGFILE_MP_BYPASS_EN defined: a read whose address matches a same-edge winning write returns that write's data. rd_busy reflects the post-update pending state of the same edge (write clear, reservation set).
- Undefined: rd_data and rd_busy come from pre-edge array and pending state, giving 1-cycle-older data on a collision. The issue logic must then re-read.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W/port counts, MAX_PEND, and a pend_cnt width function.
- Sub-module regfile_pend: pending bit vector, set/clear resolution, popcount counter, rsv_rdy. The top level holds the array, write-port priority and read/bypass muxing.

## Test plan
- Reset: write r3=0xDEAD, then rst_n=0 for 1 edge -> read r3 returns 0 with busy 0, and pend_cnt=0.
- Dual write collision: port0 r5=0x11 and port1 r5=0x22 on the same edge -> the next read of r5 returns 0x22. A write to r0 of 0xFF -> read returns 0.
- Scoreboard: reserve r7 -> rd_busy=1 and pend_cnt=1. Write r7=0x77 -> rd_busy=0, pend_cnt=0, data 0x77. Reserve and write r7 on the same edge -> busy stays 1.
- Limit: reserve r1..r4 -> rsv_rdy=0 and pend_cnt=4. Then reserve r9 -> r9 not busy. Write r2 -> rsv_rdy=1 and pend_cnt=3.
- Stall: stall=1 with rd_addr=r6 and write r6=0x66 -> rd_data unchanged. stall=0 -> 0x66. rsv_en during stall is ignored.
- Bypass (macro on): read r8 while writing r8=0xAB on the same edge -> rd_data=0xAB. With the macro off -> the old value.
